// File: rtl/in_debounce.sv
// Three-channel input conditioner. Each raw level passes through a 2-flop synchroniser and a
// stability counter; outputs flip only after DEBOUNCE consecutive cycles of disagreement.
module in_debounce #(
  parameter int unsigned DEBOUNCE = 4,
  parameter logic [2:0]  RST_VAL  = 3'b100
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic       raw_c,
  input  logic       hold,
  output logic       out_a,
  output logic       out_b,
  output logic       out_c,
  output logic [2:0] chg_vec,
  output logic       chg
);

  localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);

  logic [2:0]       raw;
  logic [2:0]       s1_q, s2_q;
  logic [2:0]       out_q, out_d;
  logic [2:0]       chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  assign raw = {raw_c, raw_b, raw_a};

  // A single cycle of agreement between s2 and out discards any pending count.
  always_comb begin
    out_d = out_q;
    chg_d = '0;
    cnt_d = cnt_q;
    if (!hold) begin
      for (int i = 0; i < 3; i++) begin
        if (s2_q[i] == out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          out_d[i] = s2_q[i];
          cnt_d[i] = '0;
          chg_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_q  <= RST_VAL;
      s2_q  <= RST_VAL;
      out_q <= RST_VAL;
      chg_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      out_q <= out_d;
      chg_q <= chg_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out_a   = out_q[0];
  assign out_b   = out_q[1];
  assign out_c   = out_q[2];
  assign chg_vec = chg_q;
  assign chg     = |chg_q;

endmodule

// File: tb/tb_in_debounce.sv
// Directed bench for in_debounce: expected {out, chg_vec, chg} per cycle are queued with the
// stimulus and popped/compared one cycle at a time, 1 time unit after each rising edge.
module tb_in_debounce;

  logic       clk = 1'b0;
  logic       reset_l = 1'b1;
  logic       raw_a = 1'b0;
  logic       raw_b = 1'b0;
  logic       raw_c = 1'b1;
  logic       hold = 1'b0;
  logic       out_a, out_b, out_c, chg;
  logic [2:0] chg_vec;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [2:0] out;
    logic [2:0] cv;
    int         step;
  } exp_t;

  exp_t sb[$];

  in_debounce #(
    .DEBOUNCE(4),
    .RST_VAL (3'b100)
  ) dut (
    .clk    (clk),
    .reset_l(reset_l),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .raw_c  (raw_c),
    .hold   (hold),
    .out_a  (out_a),
    .out_b  (out_b),
    .out_c  (out_c),
    .chg_vec(chg_vec),
    .chg    (chg)
  );

  always #5 clk = ~clk;

  task automatic push_n(input int n, input logic [2:0] o, input logic [2:0] cv, input int step);
    exp_t e;
    e.out  = o;
    e.cv   = cv;
    e.step = step;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic check_now(input logic [2:0] o, input logic [2:0] cv, input int step);
    logic [6:0] got, exp;
    got = {out_c, out_b, out_a, chg_vec, chg};
    exp = {o, cv, |cv};
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL step%0d out/chg_vec/chg got=%b_%b_%b expected=%b_%b_%b", step,
             got[6:4], got[3:1], got[0], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic run_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("FAIL scoreboard_underflow got=empty expected=entry");
      end else begin
        e = sb.pop_front();
        check_now(e.out, e.cv, e.step);
      end
    end
  endtask

  initial begin
    // Step 0: asynchronous reset state, before any clock edge.
    #2 reset_l = 1'b0;
    #1 check_now(3'b100, 3'b000, 0);
    #20 reset_l = 1'b1;
    @(posedge clk);
    #1;

    // Step 1: inputs equal to RST_VAL, nothing ever changes.
    push_n(20, 3'b100, 3'b000, 1);
    run_cycles(20);

    // Step 2: raw_a rises; out_a flips on the 6th edge with a one-cycle strobe.
    raw_a = 1'b1;
    push_n(5, 3'b100, 3'b000, 2);
    push_n(1, 3'b101, 3'b001, 2);
    push_n(4, 3'b101, 3'b000, 2);
    run_cycles(10);

    // Step 3: 3-cycle glitch on raw_b is filtered out.
    raw_b = 1'b1;
    push_n(3, 3'b101, 3'b000, 3);
    run_cycles(3);
    raw_b = 1'b0;
    push_n(8, 3'b101, 3'b000, 3);
    run_cycles(8);

    // Step 4: raw_a and raw_c change together.
    raw_a = 1'b0;
    raw_c = 1'b0;
    push_n(5, 3'b101, 3'b000, 4);
    push_n(1, 3'b000, 3'b101, 4);
    push_n(4, 3'b000, 3'b000, 4);
    run_cycles(10);

    // Step 5: hold freezes the count at 2; two more edges needed after release.
    raw_a = 1'b1;
    push_n(4, 3'b000, 3'b000, 5);
    run_cycles(4);
    hold = 1'b1;
    push_n(5, 3'b000, 3'b000, 5);
    run_cycles(5);
    hold = 1'b0;
    push_n(1, 3'b000, 3'b000, 5);
    push_n(1, 3'b001, 3'b001, 5);
    push_n(3, 3'b001, 3'b000, 5);
    run_cycles(5);

    // Step 6: reset mid-count on channel b restores RST_VAL at once and restarts the count.
    raw_b = 1'b1;
    push_n(3, 3'b001, 3'b000, 6);
    run_cycles(3);
    #2 reset_l = 1'b0;
    #1 check_now(3'b100, 3'b000, 6);
    raw_a = 1'b0;
    raw_c = 1'b1;
    #1 reset_l = 1'b1;
    push_n(5, 3'b100, 3'b000, 6);
    push_n(1, 3'b110, 3'b010, 6);
    push_n(3, 3'b110, 3'b000, 6);
    run_cycles(9);

    tests_run++;
    assert (sb.size() == 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_leftover got=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
